// File: rtl/ntt_stage_sched.sv
// In-place radix-2 NTT stage scheduler: issues butterfly operand/twiddle reads, writes the
// butterfly results back to the same addresses, and holds each stage until its last write lands.
module ntt_stage_sched #(
    parameter int unsigned DW     = 33,
    parameter int unsigned LOGN   = 8,
    parameter int unsigned BF_LAT = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] stage,
    output logic            ram_rd_en,
    output logic [LOGN-1:0] ram_rd_addr_a,
    output logic [LOGN-1:0] ram_rd_addr_b,
    input  logic [DW-1:0]   ram_rd_data_a,
    input  logic [DW-1:0]   ram_rd_data_b,
    output logic            tw_rd_en,
    output logic [LOGN-2:0] tw_addr,
    input  logic [DW-1:0]   tw_data,
    output logic            bf_en,
    output logic [DW-1:0]   bf_xin,
    output logic [DW-1:0]   bf_yin,
    output logic [DW-1:0]   bf_wr,
    input  logic [DW-1:0]   bf_xout,
    input  logic [DW-1:0]   bf_yout,
    input  logic            bf_valid,
    output logic            ram_wr_en,
    output logic [LOGN-1:0] ram_wr_addr_a,
    output logic [LOGN-1:0] ram_wr_addr_b,
    output logic [DW-1:0]   ram_wr_data_a,
    output logic [DW-1:0]   ram_wr_data_b,
    output logic            err
);

    localparam int unsigned     Dly   = BF_LAT + 1;
    localparam logic [LOGN-1:0] HalfN = LOGN'(1 << (LOGN - 1));
    localparam logic [LOGN-1:0] SLast = LOGN'(LOGN - 1);
    localparam logic [LOGN-2:0] KLast = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

    state_e            state_q, state_d;
    logic [LOGN-1:0]   s_q, s_d;
    logic [LOGN-2:0]   k_q, k_d;
    logic [LOGN-1:0]   wb_cnt_q, wb_cnt_d;
    logic [LOGN-1:0]   outst_q, outst_d;
    logic              bf_en_q;
    logic              err_q;
    logic [2*LOGN-1:0] dly_q [Dly];

    logic              stage_written;
    logic              wr_ok;

    logic [LOGN-1:0]   k_ext, h, low_mask, addr_a, addr_b, tw_shift;
    logic [LOGN:0]     s_p1;
    logic [LOGN-2:0]   tw_idx;

    // Butterfly operand addresses for (s, k): k's low s bits stay, the rest move up one bit.
    always_comb begin
        k_ext    = {1'b0, k_q};
        h        = {{(LOGN-1){1'b0}}, 1'b1} << s_q;
        low_mask = h - 1'b1;
        s_p1     = {1'b0, s_q} + 1'b1;
        addr_a   = ((k_ext >> s_q) << s_p1) | (k_ext & low_mask);
        addr_b   = addr_a + h;
        tw_shift = SLast - s_q;
        tw_idx   = (k_q & low_mask[LOGN-2:0]) << tw_shift;
    end

    assign stage_written = (wb_cnt_q == HalfN);
    // A result with nothing in flight cannot belong to any issued butterfly; drop it.
    assign wr_ok         = bf_valid && (outst_q != '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (k_q == KLast) state_d = StDrain;
            StDrain: if (stage_written) state_d = (s_q == SLast) ? StFin : StIssue;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        ram_rd_en = 1'b0;
        unique case (state_q)
            StIssue: begin
                busy      = 1'b1;
                ram_rd_en = 1'b1;
            end
            StDrain: busy = 1'b1;
            StFin:   done = 1'b1;
            default: ;
        endcase
    end

    // Stage, issue and write-back counters
    always_comb begin
        k_d      = k_q;
        s_d      = s_q;
        wb_cnt_d = wb_cnt_q + {{(LOGN-1){1'b0}}, ram_wr_en};
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d      = '0;
                    s_d      = '0;
                    wb_cnt_d = '0;
                end
            end
            StIssue: k_d = k_q + 1'b1;
            StDrain: begin
                if (stage_written && (s_q != SLast)) begin
                    s_d      = s_q + 1'b1;
                    wb_cnt_d = '0;
                end
            end
            StFin:   s_d = '0;
            default: ;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (bf_en_q && !wr_ok) begin
            outst_d = outst_q + 1'b1;
        end else if (!bf_en_q && wr_ok) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            s_q      <= '0;
            wb_cnt_q <= '0;
            outst_q  <= '0;
            bf_en_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            k_q      <= k_d;
            s_q      <= s_d;
            wb_cnt_q <= wb_cnt_d;
            outst_q  <= outst_d;
            bf_en_q  <= ram_rd_en;
            err_q    <= err_q | (bf_valid && (outst_q == '0));
        end
    end

    // Address delay line aligns each pair with its butterfly result (1 read + BF_LAT cycles).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Dly; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {ram_rd_addr_a, ram_rd_addr_b};
            for (int i = 1; i < Dly; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    always_comb begin
        stage         = s_q;
        tw_rd_en      = ram_rd_en;
        ram_rd_addr_a = ram_rd_en ? addr_a : '0;
        ram_rd_addr_b = ram_rd_en ? addr_b : '0;
        tw_addr       = ram_rd_en ? tw_idx : '0;
        bf_en         = bf_en_q;
        bf_xin        = bf_en_q ? ram_rd_data_a : '0;
        bf_yin        = bf_en_q ? ram_rd_data_b : '0;
        bf_wr         = bf_en_q ? tw_data : '0;
        ram_wr_en     = wr_ok;
        ram_wr_addr_a = wr_ok ? dly_q[Dly-1][2*LOGN-1:LOGN] : '0;
        ram_wr_addr_b = wr_ok ? dly_q[Dly-1][LOGN-1:0] : '0;
        ram_wr_data_a = wr_ok ? bf_xout : '0;
        ram_wr_data_b = wr_ok ? bf_yout : '0;
        err           = err_q;
    end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Bench for ntt_stage_sched at N=8: RAM, twiddle ROM and butterfly models, a loop-form NTT
// schedule/golden model, and one per-cycle compare process.
module tb_ntt_stage_sched;

    localparam int unsigned DW     = 33;
    localparam int unsigned LOGN   = 3;
    localparam int unsigned BF_LAT = 5;
    localparam int          N      = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, err;
    logic [LOGN-1:0] stage;
    logic            ram_rd_en, tw_rd_en, bf_en, bf_valid, ram_wr_en;
    logic [LOGN-1:0] ram_rd_addr_a, ram_rd_addr_b, ram_wr_addr_a, ram_wr_addr_b;
    logic [LOGN-2:0] tw_addr;
    logic [DW-1:0]   ram_rd_data_a, ram_rd_data_b, tw_data;
    logic [DW-1:0]   bf_xin, bf_yin, bf_wr, bf_xout, bf_yout;
    logic [DW-1:0]   ram_wr_data_a, ram_wr_data_b;

    always #5 clk = ~clk;

    ntt_stage_sched #(.DW(DW), .LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
        .ram_rd_en(ram_rd_en), .ram_rd_addr_a(ram_rd_addr_a), .ram_rd_addr_b(ram_rd_addr_b),
        .ram_rd_data_a(ram_rd_data_a), .ram_rd_data_b(ram_rd_data_b),
        .tw_rd_en(tw_rd_en), .tw_addr(tw_addr), .tw_data(tw_data),
        .bf_en(bf_en), .bf_xin(bf_xin), .bf_yin(bf_yin), .bf_wr(bf_wr),
        .bf_xout(bf_xout), .bf_yout(bf_yout), .bf_valid(bf_valid),
        .ram_wr_en(ram_wr_en), .ram_wr_addr_a(ram_wr_addr_a), .ram_wr_addr_b(ram_wr_addr_b),
        .ram_wr_data_a(ram_wr_data_a), .ram_wr_data_b(ram_wr_data_b), .err(err)
    );

    typedef struct { int a; int b; int t; int s; } rd_t;
    typedef struct { int a; int b; int due; } wr_t;

    rd_t           rd_q[$];
    wr_t           wq[$];
    rd_t           obs_q[$];
    int            checks = 0, failures = 0;
    int            cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int            last_wr_cyc = -1, cur_rd_stage = -1;
    logic          prev_rd = 1'b0, log_en = 1'b0, inject = 1'b0, init_mem = 1'b0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] gold [N];

    function automatic logic [DW-1:0] twv(input int i);
        return DW'(1000 + 7 * i);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Coefficient RAM and twiddle ROM, both with one cycle of read latency
    logic [DW-1:0] rd_a_q = '0, rd_b_q = '0, tw_q = '0;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < N; i++) mem[i] <= DW'(64'h1_2345_0000) + DW'(i * 977);
        end else if (ram_wr_en) begin
            mem[ram_wr_addr_a] <= ram_wr_data_a;
            mem[ram_wr_addr_b] <= ram_wr_data_b;
        end
        if (ram_rd_en) begin
            rd_a_q <= mem[ram_rd_addr_a];
            rd_b_q <= mem[ram_rd_addr_b];
        end
        if (tw_rd_en) tw_q <= twv(int'(tw_addr));
    end
    assign ram_rd_data_a = rd_a_q;
    assign ram_rd_data_b = rd_b_q;
    assign tw_data       = tw_q;

    // Butterfly pipeline: result valid BF_LAT cycles after bf_en; reset with the scheduler
    logic [BF_LAT-1:0] pv;
    logic [DW-1:0]     px [BF_LAT];
    logic [DW-1:0]     py [BF_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[BF_LAT-2:0], bf_en};
            px[0] <= bf_xin + bf_yin + bf_wr;
            py[0] <= bf_xin - bf_yin + bf_wr;
            for (int i = 1; i < BF_LAT; i++) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end
    assign bf_valid = pv[BF_LAT-1] | inject;
    assign bf_xout  = px[BF_LAT-1];
    assign bf_yout  = py[BF_LAT-1];

    // Schedule and golden result from the textbook group/offset loop form of the NTT
    task automatic arm();
        logic [DW-1:0] x, y, w;
        rd_t           r;
        for (int i = 0; i < N; i++) gold[i] = mem[i];
        rd_q.delete();
        wq.delete();
        cur_rd_stage = -1;
        for (int s = 0; s < LOGN; s++) begin
            for (int j = 0; j < N; j += 2 * (1 << s)) begin
                for (int i = 0; i < (1 << s); i++) begin
                    r.a = j + i;
                    r.b = j + i + (1 << s);
                    r.t = i * (N / (2 * (1 << s)));
                    r.s = s;
                    rd_q.push_back(r);
                    x = gold[r.a];
                    y = gold[r.b];
                    w = twv(r.t);
                    gold[r.a] = x + y + w;
                    gold[r.b] = x - y + w;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t we;
        rd_t re;
        rd_t ob;
        cyc++;
        if (!rst_n) begin
            rd_q.delete();
            wq.delete();
            prev_rd = 1'b0;
        end else begin
            if (wq.size() == 0) begin
                chk("no_write_expected", ram_wr_en, 0);
            end else if (ram_wr_en || cyc >= wq[0].due) begin
                we = wq.pop_front();
                chk("write_strobe", ram_wr_en, 1);
                chk("write_cycle", cyc, we.due);
                chk("wr_addr_a", ram_wr_addr_a, we.a);
                chk("wr_addr_b", ram_wr_addr_b, we.b);
                chk("wr_data_a", ram_wr_data_a, bf_xout);
                chk("wr_data_b", ram_wr_data_b, bf_yout);
                last_wr_cyc = cyc;
            end
            if (rd_q.size() == 0) begin
                chk("no_read_expected", ram_rd_en, 0);
            end else if (ram_rd_en) begin
                re = rd_q.pop_front();
                if (re.s != cur_rd_stage) begin
                    chk("raw_barrier", (wq.size() == 0) && (cyc > last_wr_cyc), 1);
                    cur_rd_stage = re.s;
                end
                chk("rd_addr_a", ram_rd_addr_a, re.a);
                chk("rd_addr_b", ram_rd_addr_b, re.b);
                chk("tw_addr", tw_addr, re.t);
                chk("stage", stage, re.s);
                we.a   = re.a;
                we.b   = re.b;
                we.due = cyc + 1 + BF_LAT;
                wq.push_back(we);
                if (log_en) begin
                    ob.a = int'(ram_rd_addr_a);
                    ob.b = int'(ram_rd_addr_b);
                    ob.t = int'(tw_addr);
                    ob.s = int'(stage);
                    obs_q.push_back(ob);
                end
            end
            chk("tw_rd_en", tw_rd_en, ram_rd_en);
            chk("bf_en", bf_en, prev_rd);
            if (bf_en) begin
                chk("bf_xin", bf_xin, ram_rd_data_a);
                chk("bf_yin", bf_yin, ram_rd_data_b);
                chk("bf_wr", bf_wr, tw_data);
            end
            prev_rd = ram_rd_en;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_queues_empty", rd_q.size() + wq.size(), 0);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start_cyc = cyc;
        chk("busy_before_accept", busy, 0);
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic pulse_start(input string name, input logic [1:0] exp_busy_rd);
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); #1 chk(name, {busy, ram_rd_en}, exp_busy_rd);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_within_budget", done_cnt - d0, 1);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s_ram[%0d]", tag, i), mem[i], gold[i]);
    endtask

    initial begin
        int lit_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int lit_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int lit_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int found, wr_after, d0, lat;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stage", stage, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_bf_en", bf_en, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1 rst_n = 1'b1; init_mem = 1'b1;
        @(posedge clk); #1 init_mem = 1'b0;

        // Plain transform; addresses pinned against the hand-derived N=8 table
        log_en = 1'b1;
        arm();
        do_start();
        wait_done(120);
        log_en = 1'b0;
        lat = done_cyc - start_cyc;
        checks++;
        if (lat < 32 || lat > 34) begin
            failures++;
            $display("FAIL done_latency: got %0d cycles expected 33 +/- 1", lat);
        end
        chk("obs_count", obs_q.size(), 12);
        for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
            chk($sformatf("lit_a[%0d]", i), obs_q[i].a, lit_a[i]);
            chk($sformatf("lit_b[%0d]", i), obs_q[i].b, lit_b[i]);
            chk($sformatf("lit_tw[%0d]", i), obs_q[i].t, lit_t[i]);
        end
        repeat (2) @(negedge clk);
        #1;
        check_mem("t1");
        chk("err_clear_t1", err, 0);

        // start pulses during ISSUE and DRAIN are ignored
        arm();
        d0 = done_cnt;
        do_start();
        pulse_start("start_in_issue", 2'b11);
        repeat (3) @(posedge clk);
        pulse_start("start_in_drain", 2'b10);
        wait_done(120);
        repeat (20) @(negedge clk);
        #1;
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after_t2", busy, 0);
        check_mem("t2");

        // Asynchronous reset at stage 1, k=2 aborts the transform
        arm();
        d0 = done_cnt;
        do_start();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk); #1;
            if (stage == 1 && ram_rd_en && ram_rd_addr_a == 4) found = 1;
        end
        chk("abort_point_reached", found, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", ram_rd_en, 0);
        chk("abort_stage", stage, 0);
        chk("abort_rd_addr_a", ram_rd_addr_a, 0);
        chk("abort_tw_addr", tw_addr, 0);
        chk("abort_bf_en", bf_en, 0);
        chk("abort_wr_en", ram_wr_en, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wr_after = 0;
        repeat (30) begin
            @(negedge clk); #1;
            if (ram_wr_en) wr_after++;
        end
        chk("no_write_after_abort", wr_after, 0);
        chk("no_done_after_abort", done_cnt - d0, 0);
        chk("idle_after_abort", busy, 0);
        arm();
        do_start();
        wait_done(120);
        repeat (2) @(negedge clk);
        #1;
        check_mem("t3");
        chk("err_clear_t3", err, 0);

        // Stray bf_valid while idle: sticky err, no write, later transform unaffected
        @(posedge clk); #1 inject = 1'b1;
        @(negedge clk); #1 chk("inject_no_write", ram_wr_en, 0);
        @(posedge clk); #1 inject = 1'b0;
        chk("err_set", err, 1);
        repeat (5) @(negedge clk);
        #1 chk("err_sticky", err, 1);
        arm();
        do_start();
        wait_done(120);
        repeat (2) @(negedge clk);
        #1;
        check_mem("t4");
        chk("err_still_set", err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

endmodule
